// File: rtl/logic_pod_trigger.sv
// logic_pod_trigger: per-pod edge/pattern trigger with 2-cycle sample delay and capture window.
// Define LOGIC_POD_TRIGGER_HOLDOFF_EN to add the cfg_holdoff re-arm holdoff.
module logic_pod_trigger #(
  parameter int POST_WIDTH = 16
) (
  input  logic                  clk_312p5mhz,
  input  logic                  rst,
  input  logic [7:0][15:0]      samples,
  input  logic [1:0]            cfg_mode,
  input  logic [2:0]            cfg_channel,
  input  logic [7:0]            cfg_pattern_mask,
  input  logic [7:0]            cfg_pattern_value,
  input  logic [POST_WIDTH-1:0] cfg_posttrig,
`ifdef LOGIC_POD_TRIGGER_HOLDOFF_EN
  input  logic [15:0]           cfg_holdoff,
`endif
  input  logic                  arm,
  input  logic                  force_trig,
  output logic [7:0][15:0]      samples_out,
  output logic                  armed,
  output logic                  triggered,
  output logic [3:0]            trig_offset,
  output logic                  capture_en,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0][15:0] s1_q, s2_q;
  logic v1_q, v2_q;
  logic [1:0] mode_q;
  logic [2:0] chan_q;
  logic [7:0] mask_q, value_q;
  logic [15:0] cur, prv, ok, pat, match_d, match_q;
  logic force_q;
  logic [POST_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0] off_q, off_d, enc;
  logic hold_ok;
`ifdef LOGIC_POD_TRIGGER_HOLDOFF_EN
  logic [15:0] hold_q, hold_d;
  assign hold_ok = hold_q == '0;
`else
  assign hold_ok = 1'b1;
`endif
  // s2_q holds the word preceding s1_q, so its bit 15 is the prior sample of index 0
  always_comb begin
    cur = s1_q[chan_q];
    prv = {cur[14:0], s2_q[chan_q][15]};
    ok = {15'h7fff, v2_q};
    pat = '1;
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < 8; i++)
        if (mask_q[i] && s1_q[i][k] != value_q[i]) pat[k] = 1'b0;
    match_d = mode_q == 2'd1 ? cur & ~prv & ok :
              mode_q == 2'd2 ? ~cur & prv & ok :
              mode_q == 2'd3 ? pat : '0;
  end
  always_comb begin
    enc = '0;
    for (int k = 15; k >= 0; k--)
      if (match_q[k]) enc = 4'(k);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    off_d = off_q;
`ifdef LOGIC_POD_TRIGGER_HOLDOFF_EN
    hold_d = hold_q;
    if (state_q == ARMED && !hold_ok) hold_d = hold_q - 16'd1;
`endif
    triggered = state_q == ARMED && hold_ok && (|match_q || force_q);
    if (triggered) begin
      state_d = cfg_posttrig == '0 ? DONE : POST;
      cnt_d = cfg_posttrig;
      off_d = enc;
    end else if (state_q == POST) begin
      cnt_d = cnt_q - POST_WIDTH'(1);
      state_d = cnt_d == '0 ? DONE : POST;
    end else if (arm && (state_q == IDLE || state_q == DONE)) begin
      state_d = ARMED;
`ifdef LOGIC_POD_TRIGGER_HOLDOFF_EN
      hold_d = cfg_holdoff;
`endif
    end
  end
  assign armed = state_q == ARMED;
  assign capture_en = triggered || state_q == POST;
  assign done = state_q == DONE;
  assign trig_offset = triggered ? enc : off_q;
  assign samples_out = s2_q;
  always_ff @(posedge clk_312p5mhz) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      mode_q <= '0;
      chan_q <= '0;
      mask_q <= '0;
      value_q <= '0;
      match_q <= '0;
      force_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      off_q <= '0;
`ifdef LOGIC_POD_TRIGGER_HOLDOFF_EN
      hold_q <= '0;
`endif
    end else begin
      s1_q <= samples;
      s2_q <= s1_q;
      v1_q <= 1'b1;
      v2_q <= v1_q;
      mode_q <= cfg_mode;
      chan_q <= cfg_channel;
      mask_q <= cfg_pattern_mask;
      value_q <= cfg_pattern_value;
      match_q <= match_d;
      force_q <= force_trig;
      state_q <= state_d;
      cnt_q <= cnt_d;
      off_q <= off_d;
`ifdef LOGIC_POD_TRIGGER_HOLDOFF_EN
      hold_q <= hold_d;
`endif
    end
  end
endmodule

// File: doc/logic_pod_trigger.md
# logic_pod_trigger

Per-pod trigger engine directly downstream of the logic pod datapath. Consumes the eight 16-sample words per 312.5 MHz cycle (5 Gsps per channel), detects an edge or pattern condition at single-sample resolution, and reports the trigger word and sample offset. Also emits a capture-enable window aligned with a delayed copy of the sample stream, for the capture buffer.

## Interface
- POST_WIDTH, 16, width of the post-trigger word counter
- clk_312p5mhz  in  1  sole clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- samples  in  la_sample_t[7:0]  per-channel words from pod datapath; within `.bits`, index 0 is oldest, index 15 newest
- cfg_mode  in  2  0 = force only, 1 = rising edge, 2 = falling edge, 3 = pattern
- cfg_channel  in  3  channel used by edge modes
- cfg_pattern_mask  in  8  pattern mode: 1 = channel participates
- cfg_pattern_value  in  8  pattern mode: required level per participating channel
- cfg_posttrig  in  POST_WIDTH  words captured after the trigger word
- arm  in  1  single-cycle arm request
- force  in  1  single-cycle manual trigger
- samples_out  out  la_sample_t[7:0]  samples delayed 2 cycles
- armed  out  1  high in ARMED
- triggered  out  1  one-cycle pulse on trigger
- trig_offset  out  4  sample index of trigger inside trigger word; held until next trigger
- capture_en  out  1  high for trigger word plus cfg_posttrig following words
- done  out  1  high in DONE

## Operation
- Stage 1 registers samples. Stage 2 computes a 16-bit per-sample match vector and runs the FSM.
- Edge match at sample k:
  - Rising edge: bit[k] = 1 and prior sample = 0.
  - Falling edge: bit[k] = 0 and prior sample = 1.
  - Prior sample of k = 0 is bit 15 of the previous word, held in a history register.
  - History is invalid for the first word after rst, so an index-0 edge in that word is suppressed.
- Pattern match at sample k: for all i with mask[i] = 1, samples[i].bits[k] == value[i]. Mask 0 matches every sample.
- trig_offset = lowest set index of the match vector (priority encode, oldest wins).
- FSM states: IDLE, ARMED, POST, DONE.
  - IDLE/DONE + arm -> ARMED.
  - ARMED + (match | force) -> POST. Asserts triggered, loads counter = cfg_posttrig, captures trig_offset. Force alone gives offset 0.
  - POST: decrement counter each cycle; when counter == 0 -> DONE.
  - arm in ARMED or POST is ignored.
  - force outside ARMED is ignored.
  - Simultaneous match and force: the match offset is used.
- capture_en = 1 in the trigger cycle and every POST cycle.
- Config inputs are sampled every cycle. Changing them while ARMED takes effect 2 cycles later; no glitch protection.
- rst:
  - FSM -> IDLE, counter = 0, history invalid.
  - armed, triggered, capture_en, done, trig_offset all 0; samples_out all 0.
  - Reset mid-POST aborts the capture immediately.

## Timing
- Word presented on samples at cycle N appears on samples_out at N+2.
- A trigger caused by word N asserts triggered, trig_offset and capture_en at N+2, coincident with that word on samples_out.
- capture_en stays high for exactly cfg_posttrig+1 cycles. cfg_posttrig = 0 gives a 1-cycle window.
- done rises the cycle after the last capture_en cycle.
- arm at cycle M: armed = 1 at M+1. A match in the word presented at M-1 (visible in stage 2 at M+1) is eligible.
- force at cycle M in ARMED: triggered at M+1 with the word then on samples_out.
- Counter arithmetic is unsigned, POST_WIDTH bits, no wrap (exits at 0).

## Configuration
- LOGIC_POD_TRIGGER_HOLDOFF_EN defined:
  - Adds input cfg_holdoff (16 bits).
  - On entering ARMED, loads a holdoff counter; matches and force are ignored while it is nonzero, and it decrements each cycle.
  - armed stays high during holdoff.
- Not defined: port absent; matches are eligible from the first ARMED cycle.

## Test plan
- Rising edge: mode 1, channel 2, arm, then channel 2 word 0x0000 followed by 0x00F0 -> triggered at 2 cycles after the 0x00F0 word, trig_offset = 4, capture_en with posttrig = 3 high 4 cycles, then done.
- Cross-word edge: channel 0 word 0x8000 (bit 15 high) then 0x0000, mode 2 -> trig_offset = 0 in the second word. Same stimulus as the first word after rst -> no trigger.
- Pattern: mask 0x0F, value 0x05; only sample 9 satisfies it -> trig_offset = 9. Mask 0x00 -> trig_offset = 0 in the first armed word.
- Force vs match: force and a match at offset 7 in the same cycle -> one triggered pulse, offset 7. Force in IDLE -> no response.
- Reset mid-POST: posttrig = 100, rst after 10 POST cycles -> next cycle all outputs 0, state IDLE. A later arm re-arms normally.
- Holdoff (macro on): holdoff = 5, match every word -> triggered 5 words later than with holdoff = 0.
